// File: rtl/car_sensor_qualifier_pkg.sv
// Shared types and constants for the country-road car sensor qualifier.
// Light encodings match the highway/country signal controller.
package car_sensor_qualifier_pkg;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUALIFY = 2'd1,
      REQUEST = 2'd2,
      SERVED  = 2'd3
   } qual_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_MIN_PRESENCE    = 3;

endpackage

// File: rtl/car_sensor_qualifier_debouncer.sv
// Two-flop synchroniser followed by a stable-sample debounce counter.
// dout changes only after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic clear_n,
   input  logic din,
   output logic dout
);

   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       sync_m;
   logic       sync_s;
   logic [7:0] db_cnt;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         sync_m <= 1'b0;
         sync_s <= 1'b0;
      end else begin
         sync_m <= din;
         sync_s <= sync_m;
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         db_cnt <= '0;
         dout   <= 1'b0;
      end else if (sync_s == dout) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         db_cnt <= '0;
         dout   <= sync_s;
      end else begin
         db_cnt <= db_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/car_sensor_qualifier.sv
// Qualifies the country-road loop detector into the controller's X input.
// Optional stuck-sensor detection is built when CAR_SENSOR_STUCK_DETECT_EN is defined.
//
// state   | meaning
// IDLE    | no car; waiting for debounced presence
// QUALIFY | presence seen; timing minimum dwell
// REQUEST | request latched, X=1 until country light goes green
// SERVED  | green given; X follows the debounced sensor
module car_sensor_qualifier
   import car_sensor_qualifier_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int MIN_PRESENCE    = DEF_MIN_PRESENCE,
   parameter int CNT_W           = 8,
   parameter int STUCK_CYCLES    = 200
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             sensor_raw,
   input  logic [1:0]       cntry_light,
   output logic             X,
   output logic [CNT_W-1:0] car_count,
   output logic             sensor_db,
   output logic             stuck_fault
);

   // The edge leaving IDLE already counts as one high sample of the dwell.
   localparam logic [7:0] QUAL_LAST = 8'((MIN_PRESENCE > 1) ? (MIN_PRESENCE - 2) : 0);

   qual_state_t state, next_state;
   logic [7:0]  dwell_cnt;
   logic        x_next;
   logic        count_inc;
   logic        is_green;

   assign is_green = (cntry_light == GREEN);

   sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clock   (clock),
      .clear_n (clear_n),
      .din     (sensor_raw),
      .dout    (sensor_db)
   );

`ifdef CAR_SENSOR_STUCK_DETECT_EN
   localparam int SW = $clog2(STUCK_CYCLES + 1);
   localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);
   logic [SW-1:0] stuck_cnt;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         stuck_cnt   <= '0;
         stuck_fault <= 1'b0;
      end else if (!sensor_db) begin
         stuck_cnt <= '0;
      end else if (stuck_cnt <= STUCK_LAST) begin
         stuck_cnt <= stuck_cnt + 1'b1;
         if (stuck_cnt == STUCK_LAST)
            stuck_fault <= 1'b1;
      end
   end
`else
   assign stuck_fault = 1'b0;
`endif

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sensor_db) next_state = QUALIFY;
         QUALIFY: if (!sensor_db) next_state = IDLE;
                  else if (dwell_cnt >= QUAL_LAST) next_state = REQUEST;
         REQUEST: if (is_green) next_state = SERVED;
         SERVED:  if (!is_green) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (stuck_fault) next_state = IDLE;
   end

   always_comb begin
      x_next    = 1'b0;
      count_inc = (state == QUALIFY) && (next_state == REQUEST);
      case (next_state)
         REQUEST: x_next = 1'b1;
         SERVED:  x_next = sensor_db;
         default: x_next = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         X         <= 1'b0;
         dwell_cnt <= '0;
         car_count <= '0;
      end else begin
         X <= x_next;
         if (state == QUALIFY) dwell_cnt <= dwell_cnt + 8'd1;
         else                  dwell_cnt <= '0;
         if (count_inc && (car_count != {CNT_W{1'b1}}))
            car_count <= car_count + 1'b1;
      end
   end

endmodule
